// File: rtl/conv_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// conv_ctrl_pkg
// Shared definitions for the convolution stream controller and its
// neighbours (weight_loader, data_accumulator):
//   - state_t : frame sequencer state encoding (also exported on `state`)
//   - wbeats(): bus beats needed to carry one KxK weight kernel
//   - rbeats(): bus beats needed to carry one K-pixel input row slice
// ---------------------------------------------------------------------------
package conv_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD_W = 2'd1,
    ST_STREAM = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  function automatic int wbeats(input int k, input int weight_w, input int bus_w);
    return ceil_div(k * k * weight_w, bus_w);
  endfunction

  function automatic int rbeats(input int k, input int data_w, input int bus_w);
    return ceil_div(k * data_w, bus_w);
  endfunction

endpackage

// File: rtl/hs_beat_counter.sv
// ---------------------------------------------------------------------------
// hs_beat_counter
// Handshake beat counter with terminal-count compare.
//   clk, rstn : clock, asynchronous active-low reset
//   clear     : synchronous clear (wins over inc)
//   inc       : one accepted handshake this cycle
//   terminal  : number of beats that completes the sequence
//   pre       : count == terminal-1 (the next accepted beat is the last one)
//   last      : inc & pre (this cycle's beat is the terminal beat)
//   reached   : count == terminal (sequence already complete)
// ---------------------------------------------------------------------------
module hs_beat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic             inc,
  input  logic [WIDTH-1:0] terminal,
  output logic             pre,
  output logic             last,
  output logic             reached
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + WIDTH'(1);
    end
  end

  assign pre     = (count == terminal - WIDTH'(1));
  assign last    = inc & pre;
  assign reached = (count == terminal);

endmodule

// File: rtl/conv_stream_ctrl.sv
// ---------------------------------------------------------------------------
// conv_stream_ctrl
// Frame sequencer for the convolution datapath. Owns the shared input
// stream and steers it first to the weight loader (when weights must be
// (re)loaded) and then to the data accumulator. Counts weight, input and
// output beats, flags the last output of a frame and reports status.
//   clk, rstn                      : clock, asynchronous active-low reset
//   start, abort                   : frame start pulse / abort current frame
//   cfg_rows, cfg_reload           : frame rows / force weight reload (at start)
//   s_axis_tvalid/tlast/tready     : shared input stream
//   wl_tvalid, wl_tready           : weight loader handshake
//   acc_tvalid, acc_tready, acc_enable : data accumulator handshake/enable
//   out_tvalid, out_tready         : observed output handshake
//   m_axis_tlast                   : last output of the frame
//   busy, done, err_cfg, err_len, weights_valid, state : status
// ---------------------------------------------------------------------------
module conv_stream_ctrl
  import conv_ctrl_pkg::*;
#(
  parameter int KERNEL_SIZE   = 3,
  parameter int DATA_WIDTH    = 8,
  parameter int WEIGHT_WIDTH  = 8,
  parameter int BUS_WIDTH     = 32,
  parameter int ROW_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start,
  input  logic                     abort,
  input  logic [ROW_CNT_WIDTH-1:0] cfg_rows,
  input  logic                     cfg_reload,
  input  logic                     s_axis_tvalid,
  input  logic                     s_axis_tlast,
  output logic                     s_axis_tready,
  output logic                     wl_tvalid,
  input  logic                     wl_tready,
  output logic                     acc_tvalid,
  input  logic                     acc_tready,
  output logic                     acc_enable,
  input  logic                     out_tvalid,
  input  logic                     out_tready,
  output logic                     m_axis_tlast,
  output logic                     busy,
  output logic                     done,
  output logic                     err_cfg,
  output logic                     err_len,
  output logic                     weights_valid,
  output logic [1:0]               state
);

  localparam int WBEATS = wbeats(KERNEL_SIZE, WEIGHT_WIDTH, BUS_WIDTH);
  localparam int RBEATS = rbeats(KERNEL_SIZE, DATA_WIDTH, BUS_WIDTH);
  localparam int WCNT_W = $clog2(WBEATS + 1);
  localparam int ICNT_W = ROW_CNT_WIDTH + $clog2(RBEATS) + 1;
  localparam int OCNT_W = ROW_CNT_WIDTH;

  state_t                   st;
  logic [ROW_CNT_WIDTH-1:0] rows_lat;

  logic              rows_ok, start_ok, counting;
  logic [ICNT_W-1:0] nin;
  logic [OCNT_W-1:0] nout;
  logic              w_hs, i_hs, o_hs;
  logic              w_pre, w_last, w_reached;
  logic              i_pre, i_last, i_reached;
  logic              o_pre, o_last, o_reached;

  assign rows_ok  = (cfg_rows >= ROW_CNT_WIDTH'(KERNEL_SIZE));
  assign start_ok = (st == ST_IDLE) & start & ~abort & rows_ok;
  assign counting = (st == ST_STREAM) | (st == ST_DRAIN);

  assign nin  = ICNT_W'(rows_lat) * ICNT_W'(RBEATS);
  assign nout = rows_lat - OCNT_W'(KERNEL_SIZE - 1);

  // Steering is purely a function of the registered state, so the first
  // ready appears the cycle after start and LOAD_W->STREAM has no bubble.
  always_comb begin
    s_axis_tready = 1'b0;
    wl_tvalid     = 1'b0;
    acc_tvalid    = 1'b0;
    acc_enable    = 1'b0;
    case (st)
      ST_LOAD_W: begin
        wl_tvalid     = s_axis_tvalid;
        s_axis_tready = wl_tready;
      end
      ST_STREAM: begin
        acc_tvalid    = s_axis_tvalid;
        s_axis_tready = acc_tready;
        acc_enable    = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_hs = (st == ST_LOAD_W) & s_axis_tvalid & wl_tready;
  assign i_hs = (st == ST_STREAM) & s_axis_tvalid & acc_tready;
  // Outputs beyond the expected count are not counted, so a frame whose
  // outputs finish early still leaves the counter parked at NOUT.
  assign o_hs = counting & out_tvalid & out_tready & ~o_reached;

  assign m_axis_tlast = out_tvalid & counting & o_pre;
  assign busy         = (st != ST_IDLE);
  assign state        = st;

  hs_beat_counter #(.WIDTH(WCNT_W)) u_wcnt (
    .clk      (clk),
    .rstn     (rstn),
    .clear    (start_ok),
    .inc      (w_hs),
    .terminal (WCNT_W'(WBEATS)),
    .pre      (w_pre),
    .last     (w_last),
    .reached  (w_reached)
  );

  hs_beat_counter #(.WIDTH(ICNT_W)) u_icnt (
    .clk      (clk),
    .rstn     (rstn),
    .clear    (start_ok),
    .inc      (i_hs),
    .terminal (nin),
    .pre      (i_pre),
    .last     (i_last),
    .reached  (i_reached)
  );

  hs_beat_counter #(.WIDTH(OCNT_W)) u_ocnt (
    .clk      (clk),
    .rstn     (rstn),
    .clear    (start_ok),
    .inc      (o_hs),
    .terminal (nout),
    .pre      (o_pre),
    .last     (o_last),
    .reached  (o_reached)
  );

  // Compare-outputs that this controller does not need.
  logic unused_cnt;
  assign unused_cnt = &{1'b0, w_pre, w_reached, i_pre, i_reached};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st            <= ST_IDLE;
      rows_lat      <= '0;
      weights_valid <= 1'b0;
      err_len       <= 1'b0;
      done          <= 1'b0;
      err_cfg       <= 1'b0;
    end else begin
      done    <= 1'b0;
      err_cfg <= 1'b0;
      if (abort) begin
        // A partially loaded kernel is unusable, so drop weights_valid.
        st <= ST_IDLE;
        if (st == ST_LOAD_W) weights_valid <= 1'b0;
      end else begin
        case (st)
          ST_IDLE: begin
            if (start) begin
              if (rows_ok) begin
                rows_lat <= cfg_rows;
                err_len  <= 1'b0;
                st       <= (cfg_reload || !weights_valid) ? ST_LOAD_W : ST_STREAM;
              end else begin
                err_cfg <= 1'b1;
              end
            end
          end
          ST_LOAD_W: begin
            if (w_last) begin
              weights_valid <= 1'b1;
              st            <= ST_STREAM;
            end
          end
          ST_STREAM: begin
            // tlast must coincide with the counted final beat; the frame
            // still ends by count either way.
            if (i_hs && (s_axis_tlast != i_last)) err_len <= 1'b1;
            if (i_last) st <= ST_DRAIN;
          end
          ST_DRAIN: begin
            if (o_last || o_reached) begin
              done <= 1'b1;
              st   <= ST_IDLE;
            end
          end
          default: st <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_conv_stream_ctrl.sv
// ---------------------------------------------------------------------------
// tb_conv_stream_ctrl
// Directed frame sequence with randomized valid/ready patterns. A
// transaction-level model tracks weight/input/output beats per frame and
// derives the expected routing, flags and status every cycle.
// ---------------------------------------------------------------------------
module tb_conv_stream_ctrl;

  localparam int K    = 3;
  localparam int RW   = 16;
  localparam int WB   = (K * K * 8 + 31) / 32;
  localparam int RB   = (K * 8 + 31) / 32;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start, abort;
  logic [RW-1:0] cfg_rows;
  logic          cfg_reload;
  logic          s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic          wl_tvalid, wl_tready;
  logic          acc_tvalid, acc_tready, acc_enable;
  logic          out_tvalid, out_tready;
  logic          m_axis_tlast;
  logic          busy, done, err_cfg, err_len, weights_valid;
  logic [1:0]    state;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  bit wv_model = 1'b0;

  always #5 clk = ~clk;

  conv_stream_ctrl dut (
    .clk           (clk),
    .rstn          (rstn),
    .start         (start),
    .abort         (abort),
    .cfg_rows      (cfg_rows),
    .cfg_reload    (cfg_reload),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .wl_tvalid     (wl_tvalid),
    .wl_tready     (wl_tready),
    .acc_tvalid    (acc_tvalid),
    .acc_tready    (acc_tready),
    .acc_enable    (acc_enable),
    .out_tvalid    (out_tvalid),
    .out_tready    (out_tready),
    .m_axis_tlast  (m_axis_tlast),
    .busy          (busy),
    .done          (done),
    .err_cfg       (err_cfg),
    .err_len       (err_len),
    .weights_valid (weights_valid),
    .state         (state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_all(input logic v);
    s_axis_tvalid = v;
    s_axis_tlast  = 1'b0;
    wl_tready     = v;
    acc_tready    = v;
    out_tvalid    = 1'b0;
    out_tready    = v;
  endtask

  // One complete frame. tlast_pos is the input beat carrying s_axis_tlast.
  task automatic run_frame(input int rows, input bit reload, input int tlast_pos, input bit rnd);
    int nin, nout, wb, ab, ob, p, cyc, hs_wl, hs_acc, n_tlast;
    bit load, errm, fin;
    logic [9:0] got, exp;
    nin = rows * RB;  nout = rows - K + 1;
    wb = 0; ab = 0; ob = 0; cyc = 0; hs_wl = 0; hs_acc = 0; n_tlast = 0;
    errm = 1'b0; fin = 1'b0;
    load = reload || !wv_model;

    drive_all(1'b1);
    start = 1'b1; cfg_rows = RW'(rows); cfg_reload = reload;
    #1;
    chk("start_cycle_idle", {30'd0, state}, 32'd0);
    next_cycle();
    start = 1'b0;

    while (!fin && cyc < 600) begin
      cyc++;
      p = (load && wb < WB) ? 1 : (ab < nin) ? 2 : 3;
      s_axis_tvalid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      wl_tready     = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      acc_tready    = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      out_tready    = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      out_tvalid    = (p >= 2 && ob < nout) ? (rnd ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b0;
      s_axis_tlast  = (p == 2) && (ab + 1 == tlast_pos);
      #1;
      got = {state, busy, s_axis_tready, wl_tvalid, acc_tvalid, acc_enable,
             m_axis_tlast, done, err_len};
      exp = {2'(p), 1'b1,
             (p == 1) ? wl_tready : (p == 2) ? acc_tready : 1'b0,
             (p == 1) & s_axis_tvalid,
             (p == 2) & s_axis_tvalid,
             (p == 2),
             out_tvalid & (p >= 2) & (ob == nout - 1),
             1'b0, errm};
      chk("frame_cycle", {22'd0, got}, {22'd0, exp});

      if (wl_tvalid && wl_tready && s_axis_tready) hs_wl++;
      if (acc_tvalid && acc_tready && s_axis_tready) hs_acc++;
      if (m_axis_tlast && out_tready) n_tlast++;

      if (p == 1 && s_axis_tvalid && wl_tready) begin
        wb++;
        if (wb == WB) wv_model = 1'b1;
      end
      if (p == 2 && s_axis_tvalid && acc_tready) begin
        ab++;
        if ((ab == tlast_pos) != (ab == nin)) errm = 1'b1;
      end
      if (p >= 2 && out_tvalid && out_tready) ob++;
      if (p == 3 && ob == nout) fin = 1'b1;
      next_cycle();
    end
    chk("frame_finished", {31'd0, fin}, 32'd1);

    drive_all(1'b1);
    #1;
    chk("done_pulse", {28'd0, state, busy, done}, {28'd0, 2'd0, 1'b0, 1'b1});
    chk("idle_no_ready", {31'd0, s_axis_tready}, 32'd0);
    chk("weights_valid", {31'd0, weights_valid}, {31'd0, wv_model});
    chk("err_len_end", {31'd0, err_len}, {31'd0, errm});
    chk("wl_beats", hs_wl, load ? WB : 0);
    chk("acc_beats", hs_acc, nin);
    chk("tlast_count", n_tlast, 1);
    $display("frame rows=%0d reload=%0d load=%0d wl=%0d acc=%0d outs=%0d err_len=%0d cycles=%0d",
             rows, reload, load, hs_wl, hs_acc, ob, err_len, cyc);
    next_cycle();
    chk("done_clear", {31'd0, done}, 32'd0);
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; abort = 1'b0; cfg_rows = '0; cfg_reload = 1'b0;
    drive_all(1'b1);
    out_tvalid = 1'b1;
    repeat (3) next_cycle();
    chk("reset_state", {24'd0, state, busy, done, err_cfg, err_len, weights_valid, m_axis_tlast},
        32'd0);
    chk("reset_ready", {29'd0, s_axis_tready, wl_tvalid, acc_tvalid}, 32'd0);
    $display("reset state=%0d busy=%0d wv=%0d", state, busy, weights_valid);
    out_tvalid = 1'b0;
    rstn = 1'b1;
    next_cycle();

    // Frame 1: load weights, 5 rows, full throughput.
    run_frame(5, 1'b1, 5, 1'b0);
    // Frame 2: weights retained, straight to STREAM.
    run_frame(4, 1'b0, 4, 1'b0);

    // Too few rows: err_cfg pulse, no frame.
    start = 1'b1; cfg_rows = RW'(2); cfg_reload = 1'b1;
    next_cycle();
    start = 1'b0;
    chk("err_cfg_pulse", {28'd0, err_cfg, state, s_axis_tready}, {28'd0, 1'b1, 2'd0, 1'b0});
    $display("cfg_error rows=2 err_cfg=%0d state=%0d", err_cfg, state);
    next_cycle();
    chk("err_cfg_clear", {31'd0, err_cfg}, 32'd0);

    // Early tlast on beat 3: err_len set and held, frame completes.
    run_frame(5, 1'b0, 3, 1'b0);

    // Abort during LOAD_W after one beat.
    start = 1'b1; cfg_rows = RW'(5); cfg_reload = 1'b1;
    next_cycle();
    start = 1'b0;
    chk("abort_in_load", {30'd0, state}, 32'd1);
    next_cycle();
    abort = 1'b1;
    #1;
    chk("abort_pending", {30'd0, state}, 32'd1);
    next_cycle();
    abort = 1'b0;
    wv_model = 1'b0;
    chk("abort_idle", {27'd0, state, busy, s_axis_tready, wl_tvalid}, 32'd0);
    chk("abort_wv", {31'd0, weights_valid}, {31'd0, wv_model});
    $display("abort state=%0d wv=%0d", state, weights_valid);
    for (int i = 0; i < 4; i++) begin
      chk("abort_no_done", {31'd0, done}, 32'd0);
      next_cycle();
    end

    // Abort and start together: abort wins.
    start = 1'b1; abort = 1'b1; cfg_rows = RW'(5);
    next_cycle();
    start = 1'b0; abort = 1'b0;
    chk("abort_start", {28'd0, state, busy, err_cfg}, 32'd0);
    $display("abort+start state=%0d", state);

    // Random backpressure frames.
    run_frame(8, 1'b0, 8, 1'b1);
    run_frame(8, 1'b1, 8, 1'b1);
    run_frame(6, 1'b0, 6, 1'b1);

    // Asynchronous reset in the middle of a frame.
    start = 1'b1; cfg_rows = RW'(8); cfg_reload = 1'b0;
    next_cycle();
    start = 1'b0;
    repeat (2) next_cycle();
    chk("mid_frame_busy", {31'd0, busy}, 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("async_reset", {29'd0, state, weights_valid}, 32'd0);
    $display("async reset state=%0d wv=%0d", state, weights_valid);
    wv_model = 1'b0;
    next_cycle();
    rstn = 1'b1;
    next_cycle();
    // After reset the kernel must be reloaded.
    run_frame(4, 1'b0, 4, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/conv_stream_ctrl.md
# conv_stream_ctrl

Frame-level sequencer for the convolution datapath: owns the shared input AXI-Stream and steers it first to the weight loader, then to the data accumulator. It counts weight beats, input row beats and PE output beats, generates `m_axis_tlast` on the last output of a frame, and reports busy/done/error. It sits between the DMA-facing slave port and the weight_loader / data_accumulator pair, and observes the output stream handshake.

## Interface
- `KERNEL_SIZE`, 3, kernel dimension K
- `DATA_WIDTH`, 8, pixel width
- `WEIGHT_WIDTH`, 8, weight width
- `BUS_WIDTH`, 32, input stream width
- `ROW_CNT_WIDTH`, 16, width of the frame row count

Reset is asynchronous and active-low (`rstn`), on a single clock (`clk`).

- `clk` in 1: clock
- `rstn` in 1: asynchronous active-low reset
- `start` in 1: frame start pulse
- `abort` in 1: abort current frame
- `cfg_rows` in ROW_CNT_WIDTH: input rows in frame, latched at start
- `cfg_reload` in 1: force weight reload, latched at start
- `s_axis_tvalid` in 1 / `s_axis_tlast` in 1 / `s_axis_tready` out 1: shared input handshake
- `wl_tvalid` out 1 / `wl_tready` in 1: to weight loader
- `acc_tvalid` out 1 / `acc_tready` in 1 / `acc_enable` out 1: to data accumulator
- `out_tvalid` in 1 / `out_tready` in 1: observed output handshake
- `m_axis_tlast` out 1: output end-of-frame
- `busy` out 1, `done` out 1 (pulse), `err_cfg` out 1 (pulse), `err_len` out 1 (sticky), `weights_valid` out 1, `state` out 2

## Operation
- Constants: WBEATS = ceil(K*K*WEIGHT_WIDTH/BUS_WIDTH) (3 at defaults); RBEATS = ceil(K*DATA_WIDTH/BUS_WIDTH) (1); frame input beats NIN = cfg_rows*RBEATS; expected outputs NOUT = cfg_rows-K+1.
- States: IDLE=0, LOAD_W=1, STREAM=2, DRAIN=3.
- IDLE: on `start` with cfg_rows ≥ K, latch cfg, clear counters and `err_len`; go to LOAD_W if `cfg_reload` or !`weights_valid`, else STREAM. If cfg_rows < K: stay IDLE, pulse `err_cfg`.
- LOAD_W: `wl_tvalid = s_axis_tvalid`, `s_axis_tready = wl_tready`; count accepted beats; on the WBEATS-th beat set `weights_valid`, go to STREAM.
- STREAM: `acc_tvalid = s_axis_tvalid`, `s_axis_tready = acc_tready`, `acc_enable=1`; count accepted beats; on beat NIN go to DRAIN. `s_axis_tlast` must be 1 exactly on beat NIN; any mismatch sets `err_len` (frame still completes by count).
- Output counter runs in STREAM and DRAIN on `out_tvalid & out_tready`. `m_axis_tlast = out_tvalid & (out_cnt == NOUT-1)`, combinational.
- DRAIN: when NOUT outputs are accepted, pulse `done`, go to IDLE. If the last output lands the same cycle as the last input beat, the next cycle goes DRAIN→IDLE immediately.
- In IDLE, `s_axis_tready`, `wl_tvalid`, `acc_tvalid` are 0. `busy = (state != IDLE)`.
- `start` while busy is ignored. `abort` in any state: go to IDLE next cycle, no `done`; `weights_valid` cleared if aborted in LOAD_W. `abort` and `start` in the same cycle: abort wins.
- Counter widths: input beats ROW_CNT_WIDTH+clog2(RBEATS)+1, output ROW_CNT_WIDTH; no wrap within a legal frame.

## Timing
- Reset values: state IDLE, all counters 0, `weights_valid=0`, `err_len=0`, `done=0`, `err_cfg=0`, `busy=0`, `m_axis_tlast=0`.
- `start` to first `s_axis_tready`: 1 cycle (registered state).
- Ready/valid steering is combinational from the registered state. There are no bubbles between LOAD_W and STREAM except the single state-update edge.
- `done` and `err_cfg` are registered single-cycle pulses.
- Asynchronous reset mid-frame: immediate return to the reset values; the weight loader must be reloaded.

## Structure
- Package `conv_ctrl_pkg`: the state enum encoding, plus the WBEATS/RBEATS ceil-division functions shared with weight_loader and data_accumulator.
- One sub-module `hs_beat_counter`: a counter parameterised by width, with clear, increment-on-handshake and terminal-count compare. It is instantiated three times (weight, input and output counters).

## Test plan
- Reset, then `start` with rows=5, reload=1: 3 weight beats go to `wl_*`, 5 beats go to `acc_*`. After 3 outputs, `m_axis_tlast` asserts on the 3rd output, then `done` pulses and `weights_valid=1`.
- Second frame, rows=4, reload=0: no LOAD_W (state goes 0→2). Exactly 2 outputs are expected, and `done` pulses after the 2nd.
- `start` with rows=2: `err_cfg` pulses, state stays IDLE, `s_axis_tready=0`.
- rows=5 with `s_axis_tlast` on beat 3: `err_len=1` and held; the frame still completes with `done`.
- `abort` during LOAD_W after 1 beat: IDLE next cycle, `weights_valid=0`, no `done`. Abort and start together: stays IDLE.
- Random `wl_tready`/`acc_tready`/`out_tready` backpressure on a rows=8 frame: beat counts are exact, with no lost or duplicated handshakes.
